// File: rtl/seg_display_driver.sv
// Eight-digit multiplexed hex display driver for the CPU display syscall.
// Clocked from the free-running clock so refresh continues after a CPU halt.
module seg_display_driver #(
   parameter int unsigned SCAN_DIV   = 4,
   parameter int unsigned NUM_DIGITS = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        disp_we,
   input  logic [31:0] disp_data,
   input  logic        halt,
   input  logic        lz_blank,
   output logic [7:0]  an,
   output logic [6:0]  seg,
   output logic        dp,
   output logic [31:0] shown_value,
   output logic [15:0] update_count
);

   localparam logic [15:0] DIV_LAST = 16'(SCAN_DIV - 1);
   localparam logic [2:0]  IDX_LAST = 3'(NUM_DIGITS - 1);

   logic [31:0] r_shown;
   logic [15:0] r_count;
   logic [15:0] r_div;
   logic [2:0]  r_idx;
   logic [7:0]  r_an;
   logic [6:0]  r_seg;
   logic        r_dp;

   logic [4:0]  w_shamt;
   logic [3:0]  w_nibble;
   logic [31:0] w_upper;
   logic        w_blank;
   logic [6:0]  w_hex;
   logic [7:0]  w_an;
   logic [6:0]  w_seg;
   logic        w_dp;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_shown <= '0;
         r_count <= '0;
      end else if (disp_we) begin
         r_shown <= disp_data;
         if (r_count != 16'hFFFF) begin
            r_count <= r_count + 16'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_div <= '0;
         r_idx <= '0;
      end else if (r_div == DIV_LAST) begin
         r_div <= '0;
         r_idx <= (r_idx == IDX_LAST) ? 3'd0 : r_idx + 3'd1;
      end else begin
         r_div <= r_div + 16'd1;
      end
   end

   // Digit field and leading-zero test both derive from the registered idx/value.
   always_comb begin
      w_shamt  = {r_idx, 2'b00};
      w_nibble = r_shown[w_shamt +: 4];
      w_upper  = r_shown >> w_shamt;
      w_blank  = lz_blank && (r_idx != 3'd0) && (w_upper == 32'd0);
   end

   always_comb begin
      w_hex = 7'h7F;
      case (w_nibble)
         4'h0: w_hex = 7'h40;
         4'h1: w_hex = 7'h79;
         4'h2: w_hex = 7'h24;
         4'h3: w_hex = 7'h30;
         4'h4: w_hex = 7'h19;
         4'h5: w_hex = 7'h12;
         4'h6: w_hex = 7'h02;
         4'h7: w_hex = 7'h78;
         4'h8: w_hex = 7'h00;
         4'h9: w_hex = 7'h10;
         4'hA: w_hex = 7'h08;
         4'hB: w_hex = 7'h03;
         4'hC: w_hex = 7'h46;
         4'hD: w_hex = 7'h21;
         4'hE: w_hex = 7'h06;
         4'hF: w_hex = 7'h0E;
         default: w_hex = 7'h7F;
      endcase
   end

   // Blanked digits keep their anode enabled so every digit gets equal on-time.
   always_comb begin
      w_an  = ~(8'b0000_0001 << r_idx);
      w_seg = w_blank ? 7'h7F : w_hex;
      w_dp  = ~(halt && (r_idx == 3'd0));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_an  <= 8'hFF;
         r_seg <= 7'h7F;
         r_dp  <= 1'b1;
      end else begin
         r_an  <= w_an;
         r_seg <= w_seg;
         r_dp  <= w_dp;
      end
   end

   assign an           = r_an;
   assign seg          = r_seg;
   assign dp           = r_dp;
   assign shown_value  = r_shown;
   assign update_count = r_count;

endmodule

// File: tb/tb_seg_display_driver.sv
// Directed scoreboard bench for seg_display_driver using SCAN_DIV=2 and SCAN_DIV=1 instances.
`timescale 1ns/1ps
module tb_seg_display_driver;

   logic        clk       = 1'b0;
   logic        rst_n     = 1'b1;
   logic        disp_we   = 1'b0;
   logic [31:0] disp_data = '0;
   logic        halt      = 1'b0;
   logic        lz_blank  = 1'b0;

   logic [7:0]  an2, an1;
   logic [6:0]  seg2, seg1;
   logic        dp2, dp1;
   logic [31:0] shown2, shown1;
   logic [15:0] cnt2, cnt1;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic [7:0] an;
      logic [6:0] seg;
      logic       dp;
   } exp_t;

   exp_t sb[$];

   // seg codes for 32'h1234ABCD, digit 0..7
   logic [6:0] seg_1234abcd [8] = '{7'h21, 7'h46, 7'h03, 7'h08, 7'h19, 7'h30, 7'h24, 7'h79};

   seg_display_driver #(.SCAN_DIV(2), .NUM_DIGITS(8)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .disp_we(disp_we), .disp_data(disp_data),
      .halt(halt), .lz_blank(lz_blank), .an(an2), .seg(seg2), .dp(dp2),
      .shown_value(shown2), .update_count(cnt2)
   );

   seg_display_driver #(.SCAN_DIV(1), .NUM_DIGITS(8)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .disp_we(disp_we), .disp_data(disp_data),
      .halt(halt), .lz_blank(lz_blank), .an(an1), .seg(seg1), .dp(dp1),
      .shown_value(shown1), .update_count(cnt1)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] an_of(input int d);
      return ~(8'(1) << (d % 8));
   endfunction

   function automatic void push(input logic [7:0] a, input logic [6:0] s, input logic d);
      exp_t e;
      e.an  = a;
      e.seg = s;
      e.dp  = d;
      sb.push_back(e);
   endfunction

   task automatic drain(input int sel, input string tag);
      exp_t e;
      int   k;
      k = 0;
      while (sb.size() > 0) begin
         @(posedge clk); #1;
         e = sb.pop_front();
         if (sel == 2) begin
            chk($sformatf("%s_an[%0d]", tag, k), {24'd0, an2}, {24'd0, e.an});
            chk($sformatf("%s_seg[%0d]", tag, k), {25'd0, seg2}, {25'd0, e.seg});
            chk($sformatf("%s_dp[%0d]", tag, k), {31'd0, dp2}, {31'd0, e.dp});
         end else begin
            chk($sformatf("%s_an[%0d]", tag, k), {24'd0, an1}, {24'd0, e.an});
            chk($sformatf("%s_seg[%0d]", tag, k), {25'd0, seg1}, {25'd0, e.seg});
            chk($sformatf("%s_dp[%0d]", tag, k), {31'd0, dp1}, {31'd0, e.dp});
         end
         k++;
      end
   endtask

   // Asynchronous reset mid-run, optional write strobe held across reset and the first edge after release.
   task automatic mid_reset(input logic we, input logic [31:0] data);
      rst_n = 1'b0;
      #1;
      chk("rst_an", {24'd0, an2}, 32'hFF);
      chk("rst_seg", {25'd0, seg2}, 32'h7F);
      chk("rst_dp", {31'd0, dp2}, 32'h1);
      chk("rst_shown", shown2, 32'h0);
      chk("rst_cnt", {16'd0, cnt2}, 32'h0);
      chk("rst_an1", {24'd0, an1}, 32'hFF);
      disp_we   = we;
      disp_data = data;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_we_ignored_shown", shown2, 32'h0);
      chk("rst_we_ignored_cnt", {16'd0, cnt2}, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      disp_we = 1'b0;
      chk("rel_an", {24'd0, an2}, 32'hFE);
      chk("rel_seg", {25'd0, seg2}, 32'h40);
      chk("rel_an1", {24'd0, an1}, 32'hFE);
      chk("rel_seg1", {25'd0, seg1}, 32'h40);
   endtask

   initial begin
      #2;
      // Reset and digit scan of 1234ABCD at SCAN_DIV=2
      mid_reset(1'b1, 32'h1234ABCD);
      chk("wr_cnt", {16'd0, cnt2}, 32'd1);
      chk("wr_shown", shown2, 32'h1234ABCD);
      @(posedge clk); #1;
      chk("scan_d0_an", {24'd0, an2}, 32'hFE);
      chk("scan_d0_seg", {25'd0, seg2}, 32'h21);
      for (int d = 1; d <= 8; d++) begin
         push(an_of(d), seg_1234abcd[d % 8], 1'b1);
         push(an_of(d), seg_1234abcd[d % 8], 1'b1);
      end
      drain(2, "scan");

      // Leading-zero blanking of 000000F0, then blanking disabled
      lz_blank = 1'b1;
      mid_reset(1'b1, 32'h000000F0);
      @(posedge clk); #1;
      chk("lz_d0_seg", {25'd0, seg2}, 32'h40);
      for (int d = 1; d <= 8; d++) begin
         logic [6:0] s;
         s = (d == 1) ? 7'h0E : ((d == 8) ? 7'h40 : 7'h7F);
         push(an_of(d), s, 1'b1);
         push(an_of(d), s, 1'b1);
      end
      drain(2, "lz_on");
      lz_blank = 1'b0;
      for (int d = 1; d <= 7; d++) begin
         logic [6:0] s;
         s = (d == 1) ? 7'h0E : 7'h40;
         push(an_of(d), s, 1'b1);
         push(an_of(d), s, 1'b1);
      end
      drain(2, "lz_off");

      // Halt decimal point on digit 0 only
      halt = 1'b1;
      mid_reset(1'b0, 32'h0);
      chk("halt_dp_first", {31'd0, dp2}, 32'h0);
      push(8'hFE, 7'h40, 1'b0);
      for (int d = 1; d <= 8; d++) begin
         push(an_of(d), 7'h40, (d == 8) ? 1'b0 : 1'b1);
         push(an_of(d), 7'h40, (d == 8) ? 1'b0 : 1'b1);
      end
      drain(2, "halt_on");
      halt = 1'b0;
      for (int d = 1; d <= 8; d++) begin
         push(an_of(d), 7'h40, 1'b1);
         push(an_of(d), 7'h40, 1'b1);
      end
      drain(2, "halt_off");

      // SCAN_DIV=1: write while idx sits at 0 just after the 7->0 wrap
      for (int k = 0; k < 20 && an1 !== 8'h7F; k++) begin
         @(posedge clk); #1;
      end
      chk("wrap_sync_an1", {24'd0, an1}, 32'h7F);
      disp_we   = 1'b1;
      disp_data = 32'h00000009;
      @(posedge clk); #1;
      disp_we = 1'b0;
      chk("wrap_old_an", {24'd0, an1}, 32'hFE);
      chk("wrap_old_seg", {25'd0, seg1}, 32'h40);
      for (int d = 1; d <= 7; d++) push(an_of(d), 7'h40, 1'b1);
      push(8'hFE, 7'h10, 1'b1);
      push(8'hFD, 7'h40, 1'b1);
      drain(1, "wrap");
      chk("wrap_cnt1", {16'd0, cnt1}, 32'd1);
      chk("wrap_shown1", shown1, 32'h00000009);

      // Saturation of the write counter
      mid_reset(1'b0, 32'h0);
      for (int i = 0; i < 65534; i++) begin
         disp_we   = 1'b1;
         disp_data = 32'hA5000000 + 32'(i);
         @(posedge clk); #1;
      end
      chk("sat_fffe", {16'd0, cnt2}, 32'hFFFE);
      chk("sat_fffe1", {16'd0, cnt1}, 32'hFFFE);
      disp_data = 32'hA5000000 + 32'd65534;
      @(posedge clk); #1;
      chk("sat_ffff", {16'd0, cnt2}, 32'hFFFF);
      for (int i = 65535; i < 65537; i++) begin
         disp_data = 32'hA5000000 + 32'(i);
         @(posedge clk); #1;
      end
      disp_we = 1'b0;
      chk("sat_hold", {16'd0, cnt2}, 32'hFFFF);
      chk("sat_hold1", {16'd0, cnt1}, 32'hFFFF);
      chk("sat_shown", shown2, 32'hA5010000);
      @(posedge clk); #1;
      chk("sat_no_we_shown", shown2, 32'hA5010000);
      chk("sat_no_we_cnt", {16'd0, cnt2}, 32'hFFFF);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
